// File: rtl/mlp_sequencer.sv
// mlp_sequencer: two-layer MLP inference sequencer (one MAC, external ROMs).
// Ports: clk/reset/start, busy/done/digit, pixel/weight/bias read ports,
// zed_out -> act_in (external sigmoid). Macro MLP_SEQ_SAT_EN: saturating fit.
module mlp_sequencer #(
  parameter int PIXELS     = 784,
  parameter int HL_NEURONS = 30,
  parameter int OL_NEURONS = 10,
  parameter int RESOLUTION = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int FRAC_BITS  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [9:0]                   pixel_addr,
  input  logic signed [RESOLUTION-1:0] pixel_data,
  output logic [14:0]                  weight_addr,
  input  logic signed [RESOLUTION-1:0] weight_data,
  output logic [5:0]                   bias_addr,
  input  logic signed [RESOLUTION-1:0] bias_data,
  output logic signed [RESOLUTION-1:0] zed_out,
  input  logic signed [RESOLUTION-1:0] act_in,
  output logic [3:0]                   digit
);

  localparam int MAXIN = (PIXELS > HL_NEURONS) ? PIXELS : HL_NEURONS;
  localparam int MAXN  = (HL_NEURONS > OL_NEURONS) ? HL_NEURONS : OL_NEURONS;
  localparam int CW    = $clog2(MAXIN + 1);
  localparam int NW    = $clog2(MAXN + 1);
  localparam int HW    = (HL_NEURONS > 1) ? $clog2(HL_NEURONS) : 1;
  localparam int PW    = 2 * RESOLUTION;

  typedef enum logic [2:0] {
    IDLE, HL_MAC, HL_WB, OL_MAC, OL_WB, DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0] cnt;
  logic [NW-1:0] nidx;

  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  sh;
  logic signed [ACC_WIDTH-1:0]  bext;
  logic signed [RESOLUTION-1:0] act_q;
  logic signed [RESOLUTION-1:0] opa;
  logic signed [RESOLUTION-1:0] fit;
  logic signed [RESOLUTION-1:0] best;
  logic [3:0]                   best_idx;
  logic [PW-1:0]                prod;
  logic                         mac;

  logic signed [RESOLUTION-1:0] hid [HL_NEURONS];

  assign busy = (state != IDLE) && (state != DONE);
  assign mac  = (state == HL_MAC) || (state == OL_MAC);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = HL_MAC;
      HL_MAC:  if (cnt == CW'(PIXELS)) state_n = HL_WB;
      HL_WB:   state_n = (nidx == NW'(HL_NEURONS - 1)) ? OL_MAC : HL_MAC;
      OL_MAC:  if (cnt == CW'(HL_NEURONS)) state_n = OL_WB;
      OL_WB:   state_n = (nidx == NW'(OL_NEURONS - 1)) ? DONE : OL_MAC;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // cnt runs 0..inputs: the last value is the drain cycle in which the
  // product for the final address is still accumulated.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      nidx <= '0;
    end else begin
      unique case (state)
        HL_MAC, OL_MAC: cnt <= cnt + CW'(1);
        HL_WB: begin
          cnt  <= '0;
          nidx <= (nidx == NW'(HL_NEURONS - 1)) ? '0 : nidx + NW'(1);
        end
        OL_WB: begin
          cnt  <= '0;
          nidx <= (nidx == NW'(OL_NEURONS - 1)) ? '0 : nidx + NW'(1);
        end
        default: begin
          cnt  <= '0;
          nidx <= '0;
        end
      endcase
    end
  end

  always_comb begin
    pixel_addr  = '0;
    weight_addr = '0;
    bias_addr   = '0;
    unique case (1'b1)
      (state == HL_MAC), (state == HL_WB): begin
        bias_addr = 6'(nidx);
        if (state == HL_MAC && cnt < CW'(PIXELS)) begin
          pixel_addr  = 10'(cnt);
          weight_addr = 15'(int'(nidx) * PIXELS + int'(cnt));
        end
      end
      (state == OL_MAC), (state == OL_WB): begin
        bias_addr = 6'(HL_NEURONS + int'(nidx));
        if (state == OL_MAC && cnt < CW'(HL_NEURONS))
          weight_addr = 15'(HL_NEURONS * PIXELS
                            + int'(nidx) * HL_NEURONS
                            + int'(cnt));
      end
      default: ;
    endcase
  end

  // Low 2R bits of a product of sign-extended operands are the signed
  // product, so an unsigned multiply of the extended values suffices.
  assign opa  = (state == OL_MAC) ? act_q : pixel_data;
  assign prod = {{RESOLUTION{opa[RESOLUTION-1]}}, opa}
              * {{RESOLUTION{weight_data[RESOLUTION-1]}}, weight_data};

  assign sh   = acc >>> FRAC_BITS;
  assign bext = {{(ACC_WIDTH-RESOLUTION){bias_data[RESOLUTION-1]}},
                 bias_data};

`ifdef MLP_SEQ_SAT_EN
  logic signed [ACC_WIDTH-1:0] sum;
  assign sum = sh + bext;

  always_comb begin
    if (!sum[ACC_WIDTH-1] && (|sum[ACC_WIDTH-2:RESOLUTION-1]))
      fit = {1'b0, {(RESOLUTION-1){1'b1}}};
    else if (sum[ACC_WIDTH-1] && !(&sum[ACC_WIDTH-2:RESOLUTION-1]))
      fit = {1'b1, {(RESOLUTION-1){1'b0}}};
    else
      fit = sum[RESOLUTION-1:0];
  end
`else
  always_comb begin
    fit = RESOLUTION'(sh + bext);
  end
`endif

  assign zed_out = ((state == HL_WB) || (state == OL_WB)) ? fit : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      act_q    <= '0;
      best     <= '0;
      best_idx <= '0;
      done     <= 1'b0;
      digit    <= '0;
      for (int k = 0; k < HL_NEURONS; k++) hid[k] <= '0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) digit <= best_idx;
      if (mac) begin
        if (cnt == '0) acc <= '0;
        else acc <= acc + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
      end
      // Register-file read mirrors the 1-cycle latency of the pixel port.
      if (state == OL_MAC)
        act_q <= (cnt < CW'(HL_NEURONS)) ? hid[cnt[HW-1:0]] : '0;
      if (state == HL_WB) hid[nidx[HW-1:0]] <= act_in;
      if (state == OL_WB && (nidx == '0 || act_in > best)) begin
        best     <= act_in;
        best_idx <= 4'(nidx);
      end
    end
  end

endmodule

// File: tb/tb_mlp_sequencer.sv
// tb_mlp_sequencer: default-size instance for latency/reset/argmax corners,
// small instance for random vectors against a behavioural MLP model.
module tb_mlp_sequencer;

  localparam int SP  = 5;
  localparam int SH  = 3;
  localparam int SO  = 4;
  localparam int SWN = SH * SP + SO * SH;
  localparam int SLAT = 42;
  localparam int BLAT = 23901;

  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              b_reset, b_start, b_busy, b_done;
  logic [9:0]        b_pa;
  logic [14:0]       b_wa;
  logic [5:0]        b_ba;
  logic signed [7:0] b_pd, b_wd, b_bd, b_zed, b_act;
  logic [3:0]        b_digit;
  int                bmode = 0;

  logic              s_reset, s_start, s_busy, s_done;
  logic [9:0]        s_pa;
  logic [14:0]       s_wa;
  logic [5:0]        s_ba;
  logic signed [7:0] s_pd, s_wd, s_bd, s_zed, s_act;
  logic [3:0]        s_digit;

  logic signed [7:0] s_pix [SP];
  logic signed [7:0] s_w   [SWN];
  logic signed [7:0] s_b   [SH + SO];
  logic signed [7:0] exp_hz [SH];
  logic signed [7:0] exp_oz [SO];
  logic [3:0]        exp_dig;

  mlp_sequencer u_big (
    .clk(clk), .reset(b_reset), .start(b_start),
    .busy(b_busy), .done(b_done),
    .pixel_addr(b_pa), .pixel_data(b_pd),
    .weight_addr(b_wa), .weight_data(b_wd),
    .bias_addr(b_ba), .bias_data(b_bd),
    .zed_out(b_zed), .act_in(b_act), .digit(b_digit)
  );

  mlp_sequencer #(
    .PIXELS(SP), .HL_NEURONS(SH), .OL_NEURONS(SO),
    .RESOLUTION(8), .ACC_WIDTH(32), .FRAC_BITS(4)
  ) u_small (
    .clk(clk), .reset(s_reset), .start(s_start),
    .busy(s_busy), .done(s_done),
    .pixel_addr(s_pa), .pixel_data(s_pd),
    .weight_addr(s_wa), .weight_data(s_wd),
    .bias_addr(s_ba), .bias_data(s_bd),
    .zed_out(s_zed), .act_in(s_act), .digit(s_digit)
  );

  function automatic logic signed [7:0] sig(input logic signed [7:0] z);
    logic signed [7:0] h;
    h = z >>> 1;
    return h + 8'sd3;
  endfunction

  assign b_act = b_zed;
  assign s_act = sig(s_zed);

  always @(posedge clk) begin
    b_pd <= (bmode == 1 && b_pa < 10'd784) ? 8'sd127 : 8'sd0;
    b_wd <= (bmode == 1 && b_wa < 15'd23820) ? 8'sd127 : 8'sd0;
    if (bmode == 2)                   b_bd <= 8'sd20;
    else if (bmode == 0 && b_ba == 6'd37) b_bd <= 8'sd50;
    else                              b_bd <= 8'sd0;
    s_pd <= (int'(s_pa) < SP) ? s_pix[s_pa[2:0]] : 8'sd0;
    s_wd <= (int'(s_wa) < SWN) ? s_w[s_wa[4:0]] : 8'sd0;
    s_bd <= (int'(s_ba) < SH + SO) ? s_b[s_ba[2:0]] : 8'sd0;
  end

  task automatic chk(input string name,
                     input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [7:0] fit8(input longint v);
    logic signed [7:0] r;
`ifdef MLP_SEQ_SAT_EN
    if (v > 127)  return 8'sd127;
    if (v < -128) return 8'sh80;
`endif
    r = v[7:0];
    return r;
  endfunction

  function automatic void model();
    longint acc;
    logic signed [7:0] ha [SH];
    logic signed [7:0] oa, bst;
    for (int n = 0; n < SH; n++) begin
      acc = 0;
      for (int i = 0; i < SP; i++)
        acc += longint'(s_pix[i]) * longint'(s_w[n*SP + i]);
      exp_hz[n] = fit8((acc >>> 4) + longint'(s_b[n]));
      ha[n] = sig(exp_hz[n]);
    end
    bst = 0;
    exp_dig = 0;
    for (int m = 0; m < SO; m++) begin
      acc = 0;
      for (int i = 0; i < SH; i++)
        acc += longint'(ha[i]) * longint'(s_w[SH*SP + m*SH + i]);
      exp_oz[m] = fit8((acc >>> 4) + longint'(s_b[SH + m]));
      oa = sig(exp_oz[m]);
      if (m == 0 || oa > bst) begin
        bst = oa;
        exp_dig = 4'(m);
      end
    end
  endfunction

  task automatic chk_big_reset(input string tag);
    chk({tag, "_busy"}, b_busy, 0);
    chk({tag, "_done"}, b_done, 0);
    chk({tag, "_digit"}, b_digit, 0);
    chk({tag, "_zed"}, b_zed, 0);
    chk({tag, "_addr"}, {b_pa, b_wa, b_ba}, 0);
  endtask

  // Called one sample point (#1 after an edge) into a cycle.
  task automatic big_run(input int mode, input int repulse_at,
                         input int reset_at, input int zed_at,
                         input logic signed [7:0] zed_exp,
                         output int seen, output int pulses,
                         output logic [3:0] dig);
    bmode = mode;
    seen = -1;
    pulses = 0;
    dig = 4'hx;
    b_start = 1'b1;
    @(posedge clk);
    #1 b_start = 1'b0;
    for (int cyc = 1; cyc <= BLAT + 200; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) chk("busy_running", b_busy, 1);
      if (zed_at > 0 && cyc == zed_at) chk("hl_zed0", b_zed, zed_exp);
      if (repulse_at > 0 && cyc == repulse_at) b_start = 1'b1;
      if (repulse_at > 0 && cyc == repulse_at + 1) b_start = 1'b0;
      if (b_done) begin
        pulses++;
        if (seen < 0) begin
          seen = cyc;
          dig = b_digit;
        end
      end
      if (reset_at > 0 && cyc == reset_at) b_reset = 1'b1;
      if (reset_at > 0 && cyc == reset_at + 1) begin
        chk("no_done_before_reset", pulses, 0);
        chk_big_reset("midreset");
        b_reset = 1'b0;
        break;
      end
      if (seen >= 0 && cyc == seen + 1) begin
        chk("busy_after_done", b_busy, 0);
        chk("done_one_cycle", b_done, 0);
      end
      if (seen >= 0 && cyc == seen + 20) begin
        chk("digit_hold", b_digit, dig);
        break;
      end
    end
  endtask

  task automatic small_run(input int idx);
    int seen;
    for (int i = 0; i < SP; i++) s_pix[i] = 8'($urandom);
    for (int i = 0; i < SWN; i++) s_w[i] = 8'($urandom);
    for (int i = 0; i < SH + SO; i++) s_b[i] = 8'($urandom_range(0, 255));
    model();
    seen = -1;
    s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    for (int cyc = 1; cyc <= SLAT + 10; cyc++) begin
      @(posedge clk);
      #1;
      for (int n = 0; n < SH; n++)
        if (cyc == (n + 1) * (SP + 2) - 1)
          chk($sformatf("s_hzed r%0d n%0d", idx, n), s_zed, exp_hz[n]);
      for (int m = 0; m < SO; m++)
        if (cyc == SH * (SP + 2) + (m + 1) * (SH + 2) - 1)
          chk($sformatf("s_ozed r%0d m%0d", idx, m), s_zed, exp_oz[m]);
      if (s_done && seen < 0) seen = cyc;
    end
    chk($sformatf("s_latency r%0d", idx), seen, SLAT);
    chk($sformatf("s_digit r%0d", idx), s_digit, exp_dig);
  endtask

  typedef struct {
    int         mode;
    int         repulse;
    int         exp_lat;
    logic [3:0] exp_digit;
  } run_vec_t;

  run_vec_t vecs [2];

  initial begin
    int seen, pulses;
    logic [3:0] dig;
    logic signed [7:0] hz_exp;

    vecs[0] = '{2, 0, BLAT, 4'd0};
    vecs[1] = '{0, 500, BLAT, 4'd7};

    b_reset = 1'b1;
    s_reset = 1'b1;
    b_start = 1'b0;
    s_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_big_reset("reset");
    chk("s_reset_busy", s_busy, 0);
    b_reset = 1'b0;
    s_reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_busy", b_busy, 0);

    for (int v = 0; v < 2; v++) begin
      big_run(vecs[v].mode, vecs[v].repulse, 0, 0, 8'sd0,
              seen, pulses, dig);
      chk($sformatf("latency v%0d", v), seen, vecs[v].exp_lat);
      chk($sformatf("done_pulses v%0d", v), pulses, 1);
      chk($sformatf("digit v%0d", v), dig, vecs[v].exp_digit);
    end

`ifdef MLP_SEQ_SAT_EN
    hz_exp = 8'sd127;
`else
    hz_exp = 8'sd49;
`endif
    big_run(1, 0, 800, 785, hz_exp, seen, pulses, dig);

    big_run(0, 0, 1000, 0, 8'sd0, seen, pulses, dig);
    big_run(0, 0, 0, 0, 8'sd0, seen, pulses, dig);
    chk("restart_latency", seen, BLAT);
    chk("restart_pulses", pulses, 1);
    chk("restart_digit", dig, 7);

    for (int r = 0; r < 20; r++) small_run(r);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
